// File: rtl/gba_clk_pkg.sv
// rtl/gba_clk_pkg.sv - shared states, defaults and clock constants for the GBA clock controller
package gba_clk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_LOCK = 2'd0;
    localparam state_t ST_STABLE    = 2'd1;
    localparam state_t ST_HOLD      = 2'd2;
    localparam state_t ST_RUN       = 2'd3;

    localparam int DEF_DIV         = 4;
    localparam int DEF_RTC_DIV     = 512;
    localparam int DEF_LOCK_CYCLES = 1024;
    localparam int DEF_HOLD_CYCLES = 64;

    localparam int GBA_MCLK_HZ = 16_777_216;
    localparam int CORE_CLK_HZ = 4 * GBA_MCLK_HZ;
    localparam int RTC_HZ      = GBA_MCLK_HZ / DEF_RTC_DIV;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gba_sync2.sv
// rtl/gba_sync2.sv - two-flop synchroniser for an asynchronous status input
module gba_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two stages give the first flop a full cycle to resolve metastability.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/gba_clk_ctrl.sv
// rtl/gba_clk_ctrl.sv - PLL lock qualification, core reset sequencing and GBA clock enables
module gba_clk_ctrl
    import gba_clk_pkg::*;
#(
    parameter int DIV         = DEF_DIV,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int RTC_DIV     = DEF_RTC_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pll_locked_i,
    input  logic reset_req_i,
    input  logic pause_i,
    output logic core_reset_o,
    output logic ce_cpu_o,
    output logic ce_cpu_n_o,
    output logic ce_32k_o,
    output logic running_o
);

    localparam int PW = cnt_width(DIV);
    localparam int LW = cnt_width(LOCK_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int RW = cnt_width(RTC_DIV);

    localparam logic [PW-1:0] PH_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_HALF   = PW'(DIV / 2 - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RTC_LAST  = RW'(RTC_DIV - 1);

    logic          locked_s;
    state_t        state_q, state_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [RW-1:0] rtc_cnt_q, rtc_cnt_d;
    logic          core_reset_q, running_q;
    logic          ce_cpu_q, ce_cpu_n_q, ce_32k_q;
    logic          ce_cpu_d, ce_cpu_n_d, ce_32k_d;
    logic          cnt_run;
    logic          ce_mask;

    gba_sync2 u_lock_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (pll_locked_i),
        .sync_o  (locked_s)
    );

    // Sequencer: losing lock wins over everything else and restarts qualification.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
        hold_cnt_d = '0;
        if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: state_d = ST_STABLE;
                ST_STABLE: begin
                    if (lock_cnt_q == LOCK_LAST) state_d = ST_HOLD;
                    else                         lock_cnt_d = lock_cnt_q + 1'b1;
                end
                ST_HOLD: begin
                    if (reset_req_i)                  hold_cnt_d = '0;
                    else if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
                    else                              hold_cnt_d = hold_cnt_q + 1'b1;
                end
                default: begin
                    if (reset_req_i) state_d = ST_HOLD;
                end
            endcase
        end
    end

    // Timebase: phase and RTC prescaler run only while staying within HOLD/RUN,
    // so entering HOLD always starts from phase 0 and lock loss drops a partial period.
    always_comb begin
        cnt_run   = (state_q == ST_HOLD || state_q == ST_RUN) &&
                    (state_d == ST_HOLD || state_d == ST_RUN);
        phase_d   = '0;
        rtc_cnt_d = '0;
        if (cnt_run) begin
            if (phase_q == PH_LAST) begin
                phase_d   = '0;
                rtc_cnt_d = (rtc_cnt_q == RTC_LAST) ? '0 : rtc_cnt_q + 1'b1;
            end else begin
                phase_d   = phase_q + 1'b1;
                rtc_cnt_d = rtc_cnt_q;
            end
        end
        ce_mask    = pause_i && (state_d == ST_RUN);
        ce_cpu_d   = cnt_run && (phase_d == PH_LAST) && !ce_mask;
        ce_cpu_n_d = cnt_run && (phase_d == PH_HALF) && !ce_mask;
        ce_32k_d   = cnt_run && (phase_d == PH_LAST) && (rtc_cnt_d == RTC_LAST);
    end

    // State, counters and registered outputs all move on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_WAIT_LOCK;
            lock_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            phase_q      <= '0;
            rtc_cnt_q    <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            ce_cpu_q     <= 1'b0;
            ce_cpu_n_q   <= 1'b0;
            ce_32k_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            phase_q      <= phase_d;
            rtc_cnt_q    <= rtc_cnt_d;
            core_reset_q <= (state_d != ST_RUN);
            running_q    <= (state_d == ST_RUN);
            ce_cpu_q     <= ce_cpu_d;
            ce_cpu_n_q   <= ce_cpu_n_d;
            ce_32k_q     <= ce_32k_d;
        end
    end

    assign core_reset_o = core_reset_q;
    assign running_o    = running_q;
    assign ce_cpu_o     = ce_cpu_q;
    assign ce_cpu_n_o   = ce_cpu_n_q;
    assign ce_32k_o     = ce_32k_q;

endmodule
